// File: rtl/tmds_encoder_multi_if.sv
// Symbol-rate bus between the timing generator, the multi-lane TMDS encoder
// and the serialisers: clock enable, shared mode, per-lane payloads and symbols.
interface tmds_encoder_multi_if #(
  parameter int NUM_CH = 3
);
  logic                    ce_in;
  logic [1:0]              mode_in;
  logic [8*NUM_CH-1:0]     data_in;
  logic [2*NUM_CH-1:0]     control_in;
  logic [4*NUM_CH-1:0]     terc4_in;
  logic [10*NUM_CH-1:0]    tmds_out;

  modport master (
    output ce_in, mode_in, data_in, control_in, terc4_in,
    input  tmds_out
  );

  modport slave (
    input  ce_in, mode_in, data_in, control_in, terc4_in,
    output tmds_out
  );
endinterface

// File: rtl/tmds_encoder_multi.sv
// Two-stage TMDS encoder for NUM_CH lanes: video (DC balanced), control, TERC4, guard band.
// Define TMDS_TERC4_EN to build the TERC4 and guard-band modes; otherwise modes 10/11 act as control.
module tmds_encoder_multi #(
  parameter int NUM_CH = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  tmds_encoder_multi_if.slave  bus
);

  localparam logic [1:0] MODE_CTRL  = 2'b00;
  localparam logic [1:0] MODE_VIDEO = 2'b01;
`ifdef TMDS_TERC4_EN
  localparam logic [1:0] MODE_TERC4 = 2'b10;
  localparam logic [1:0] MODE_GUARD = 2'b11;
`endif

  function automatic logic [3:0] f_ones8(input logic [7:0] d);
    logic [3:0] n;
    n = 4'd0;
    for (int k = 0; k < 8; k++) begin
      n = n + {3'b000, d[k]};
    end
    return n;
  endfunction

  // Transition-minimised byte; q[8]=1 marks the XOR form, q[8]=0 the XNOR form.
  function automatic logic [8:0] f_qm(input logic [7:0] d);
    logic [8:0] q;
    logic       use_xnor;
    use_xnor = (f_ones8(d) > 4'd4) || ((f_ones8(d) == 4'd4) && (d[0] == 1'b0));
    q[0] = d[0];
    for (int k = 1; k < 8; k++) begin
      q[k] = use_xnor ? ~(q[k-1] ^ d[k]) : (q[k-1] ^ d[k]);
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

  function automatic logic [9:0] f_ctrl_sym(input logic [1:0] c);
    logic [9:0] s;
    case (c)
      2'b00:   s = 10'b1101010100;
      2'b01:   s = 10'b0010101011;
      2'b10:   s = 10'b0101010100;
      2'b11:   s = 10'b1010101011;
      default: s = 10'b1101010100;
    endcase
    return s;
  endfunction

`ifdef TMDS_TERC4_EN
  function automatic logic [9:0] f_terc4_sym(input logic [3:0] t);
    logic [9:0] s;
    case (t)
      4'h0:    s = 10'b1010011100;
      4'h1:    s = 10'b1001100011;
      4'h2:    s = 10'b1011100100;
      4'h3:    s = 10'b1011100010;
      4'h4:    s = 10'b0101110001;
      4'h5:    s = 10'b0100011110;
      4'h6:    s = 10'b0110001110;
      4'h7:    s = 10'b0100111100;
      4'h8:    s = 10'b1011001100;
      4'h9:    s = 10'b0100111001;
      4'hA:    s = 10'b0110011100;
      4'hB:    s = 10'b1011000110;
      4'hC:    s = 10'b1010001110;
      4'hD:    s = 10'b1001110001;
      4'hE:    s = 10'b0101100011;
      4'hF:    s = 10'b1011000011;
      default: s = 10'b1010011100;
    endcase
    return s;
  endfunction
`else
  logic w_unused_terc4;
  assign w_unused_terc4 = ^bus.terc4_in;
`endif

  logic [1:0]             r_s1_mode;
  logic [10*NUM_CH-1:0]   w_tmds_all;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_s1_mode <= MODE_CTRL;
    end else if (bus.ce_in) begin
      r_s1_mode <= bus.mode_in;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
`ifdef TMDS_TERC4_EN
    localparam bit GUARD_ALT = ((g % 3) == 1);
    logic [3:0]        r_s1_terc4;
`endif
    logic [8:0]        r_s1_qm;
    logic [3:0]        r_s1_n1;
    logic [1:0]        r_s1_ctrl;
    logic signed [4:0] r_cnt;
    logic [9:0]        r_tmds;
    logic [8:0]        w_qm;
    logic signed [4:0] w_n1;
    logic signed [4:0] w_bal;
    logic [9:0]        w_sym;
    logic signed [4:0] w_cnt_nxt;

    assign w_qm  = f_qm(bus.data_in[8*g +: 8]);
    assign w_n1  = $signed({1'b0, r_s1_n1});
    assign w_bal = w_n1 - (5'sd8 - w_n1);

    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
        r_s1_qm   <= 9'd0;
        r_s1_n1   <= 4'd0;
        r_s1_ctrl <= 2'b00;
`ifdef TMDS_TERC4_EN
        r_s1_terc4 <= 4'd0;
`endif
      end else if (bus.ce_in) begin
        r_s1_qm   <= w_qm;
        r_s1_n1   <= f_ones8(w_qm[7:0]);
        r_s1_ctrl <= bus.control_in[2*g +: 2];
`ifdef TMDS_TERC4_EN
        r_s1_terc4 <= bus.terc4_in[4*g +: 4];
`endif
      end
    end

    // w_bal is N1-N0 of the registered q_m; every non-video symbol restarts disparity.
    always_comb begin
      w_sym     = 10'd0;
      w_cnt_nxt = r_cnt;
      case (r_s1_mode)
        MODE_VIDEO: begin
          if ((r_cnt == 5'sd0) || (w_bal == 5'sd0)) begin
            if (r_s1_qm[8]) begin
              w_sym     = {2'b01, r_s1_qm[7:0]};
              w_cnt_nxt = r_cnt + w_bal;
            end else begin
              w_sym     = {2'b10, ~r_s1_qm[7:0]};
              w_cnt_nxt = r_cnt - w_bal;
            end
          end else if (((r_cnt > 5'sd0) && (w_bal > 5'sd0)) ||
                       ((r_cnt < 5'sd0) && (w_bal < 5'sd0))) begin
            w_sym     = {1'b1, r_s1_qm[8], ~r_s1_qm[7:0]};
            w_cnt_nxt = r_cnt + (r_s1_qm[8] ? 5'sd2 : 5'sd0) - w_bal;
          end else begin
            w_sym     = {1'b0, r_s1_qm[8], r_s1_qm[7:0]};
            w_cnt_nxt = r_cnt + w_bal - (r_s1_qm[8] ? 5'sd0 : 5'sd2);
          end
        end
`ifdef TMDS_TERC4_EN
        MODE_TERC4: begin
          w_sym     = f_terc4_sym(r_s1_terc4);
          w_cnt_nxt = 5'sd0;
        end
        MODE_GUARD: begin
          w_sym     = GUARD_ALT ? 10'b0100110011 : 10'b1011001100;
          w_cnt_nxt = 5'sd0;
        end
`endif
        default: begin
          w_sym     = f_ctrl_sym(r_s1_ctrl);
          w_cnt_nxt = 5'sd0;
        end
      endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
        r_tmds <= 10'd0;
        r_cnt  <= 5'sd0;
      end else if (bus.ce_in) begin
        r_tmds <= w_sym;
        r_cnt  <= w_cnt_nxt;
      end
    end

    assign w_tmds_all[10*g +: 10] = r_tmds;
  end

  assign bus.tmds_out = w_tmds_all;

endmodule

// File: tb/tb_tmds_encoder_multi.sv
// Self-checking bench: running-disparity model of the TMDS lanes checked every cycle,
// plus hand-computed symbols for reset, control, DC balance, TERC4/guard and stalls.
module tb_tmds_encoder_multi;
  localparam int N = 3;

  localparam logic [9:0] CTRL_TAB [4] = '{10'b1101010100, 10'b0010101011,
                                          10'b0101010100, 10'b1010101011};
  localparam logic [9:0] TERC4_TAB [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  tmds_encoder_multi_if #(.NUM_CH(N)) bus ();
  tmds_encoder_multi #(.NUM_CH(N)) dut (.clk_in(clk_in), .rst_in(rst_in), .bus(bus.slave));

  always #5 clk_in = ~clk_in;

  // Model: symbols pending in stage 1 and the disparity of everything emitted so far.
  logic [1:0]    p_mode;
  logic [8*N-1:0]  p_data;
  logic [2*N-1:0]  p_ctrl;
  logic [4*N-1:0]  p_terc4;
  logic [10*N-1:0] m_out;
  int              m_cnt [N];

  task automatic model_reset();
    p_mode = 2'b00; p_data = '0; p_ctrl = '0; p_terc4 = '0; m_out = '0;
    for (int l = 0; l < N; l++) m_cnt[l] = 0;
  endtask

  task automatic model_lane(input int lane, input logic [1:0] mode, input logic [7:0] d,
                            input logic [1:0] c, input logic [3:0] t,
                            inout int cnt, output logic [9:0] sym);
    logic [7:0] qm;
    logic       q8, inv;
    int         nd, n1;
    sym = CTRL_TAB[c];
`ifdef TMDS_TERC4_EN
    if (mode == 2'b10) sym = TERC4_TAB[t];
    if (mode == 2'b11) sym = (lane % 3 == 1) ? 10'b0100110011 : 10'b1011001100;
`endif
    if (mode == 2'b01) begin
      nd = $countones(d);
      q8 = !((nd > 4) || (nd == 4 && d[0] == 1'b0));
      qm[0] = d[0];
      for (int k = 1; k < 8; k++) qm[k] = q8 ? (qm[k-1] ^ d[k]) : ~(qm[k-1] ^ d[k]);
      n1 = $countones(qm);
      if (cnt == 0 || n1 == 4) inv = !q8;
      else inv = ((cnt > 0) == (n1 > 4));
      sym = {inv, q8, inv ? ~qm : qm};
      cnt = cnt + 2 * $countones(sym) - 10;
    end else begin
      cnt = 0;
    end
  endtask

  task automatic chk(input string name, input int lane, input logic [9:0] act, input logic [9:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s lane %0d: got %b expected %b", name, lane, act, exp);
    end
  endtask

  task automatic cycle(input logic ce, input logic [1:0] mode, input logic [8*N-1:0] data,
                       input logic [2*N-1:0] ctrl, input logic [4*N-1:0] terc4);
    logic [9:0] sym;
    bus.ce_in = ce; bus.mode_in = mode; bus.data_in = data;
    bus.control_in = ctrl; bus.terc4_in = terc4;
    @(posedge clk_in);
    if (!rst_in && ce) begin
      for (int l = 0; l < N; l++) begin
        model_lane(l, p_mode, p_data[8*l +: 8], p_ctrl[2*l +: 2], p_terc4[4*l +: 4], m_cnt[l], sym);
        m_out[10*l +: 10] = sym;
      end
      p_mode = mode; p_data = data; p_ctrl = ctrl; p_terc4 = terc4;
    end
    @(negedge clk_in);
    for (int l = 0; l < N; l++) chk("stream", l, bus.tmds_out[10*l +: 10], m_out[10*l +: 10]);
  endtask

  function automatic logic [9:0] lane_out(input int l);
    return bus.tmds_out[10*l +: 10];
  endfunction

  initial begin
    logic [9:0] exp_t, exp_g0, exp_g1;
    model_reset();
    bus.ce_in = 1'b0; bus.mode_in = 2'b00; bus.data_in = '0; bus.control_in = '0; bus.terc4_in = '0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    for (int l = 0; l < N; l++) chk("reset_hold", l, lane_out(l), 10'd0);
    rst_in = 1'b0;

    // First enabled edge after release emits the stage-1 reset contents.
    cycle(1'b1, 2'b01, 24'h5A3C81, 6'b000000, 12'h000);
    for (int l = 0; l < N; l++) chk("post_reset", l, lane_out(l), 10'b1101010100);

    cycle(1'b1, 2'b00, 24'h000000, 6'b110001, 12'h000);
    cycle(1'b1, 2'b00, 24'h000000, 6'b110001, 12'h000);
    chk("ctrl01", 0, lane_out(0), 10'b0010101011);
    chk("ctrl11", 2, lane_out(2), 10'b1010101011);

    // DC balance on all-zero bytes: disparity -8, +2, -6.
    cycle(1'b1, 2'b01, 24'h000000, 6'b000000, 12'h000);
    cycle(1'b1, 2'b01, 24'h000000, 6'b000000, 12'h000);
    chk("video0_a", 0, lane_out(0), 10'b0100000000);
    cycle(1'b1, 2'b01, 24'h000000, 6'b000000, 12'h000);
    chk("video0_b", 0, lane_out(0), 10'b1111111111);
    cycle(1'b1, 2'b00, 24'h000000, 6'b000000, 12'h000);
    chk("video0_c", 0, lane_out(0), 10'b0100000000);
    cycle(1'b1, 2'b01, 24'h000000, 6'b000000, 12'h000);
    chk("ctrl_gap", 0, lane_out(0), 10'b1101010100);
    cycle(1'b1, 2'b00, 24'h000000, 6'b000000, 12'h000);
    chk("cnt_restart", 0, lane_out(0), 10'b0100000000);

`ifdef TMDS_TERC4_EN
    exp_t = 10'b0110011100; exp_g0 = 10'b1011001100; exp_g1 = 10'b0100110011;
`else
    exp_t = 10'b1101010100; exp_g0 = 10'b1101010100; exp_g1 = 10'b1101010100;
`endif
    cycle(1'b1, 2'b10, 24'h000000, 6'b000000, 12'h00A);
    cycle(1'b1, 2'b11, 24'h000000, 6'b000000, 12'h000);
    chk("terc4_A", 0, lane_out(0), exp_t);
    cycle(1'b1, 2'b00, 24'h000000, 6'b000000, 12'h000);
    chk("guard", 0, lane_out(0), exp_g0);
    chk("guard", 1, lane_out(1), exp_g1);
    chk("guard", 2, lane_out(2), exp_g0);

    // Video burst with a three-cycle stall; inputs keep changing while ce_in is low.
    for (int i = 0; i < 14; i++)
      cycle((i >= 5 && i < 8) ? 1'b0 : 1'b1, 2'b01, 24'($urandom), 6'($urandom), 12'($urandom));

    // Mixed modes, data and enables.
    for (int i = 0; i < 60; i++)
      cycle(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
            (i % 7 == 6) ? 2'($urandom) : 2'b01,
            24'($urandom), 6'($urandom), 12'($urandom));

    // Asynchronous reset between edges while video is streaming.
    #2 rst_in = 1'b1;
    #1;
    model_reset();
    for (int l = 0; l < N; l++) chk("async_reset", l, lane_out(l), 10'd0);
    cycle(1'b1, 2'b01, 24'hFFFFFF, 6'b000000, 12'h000);
    rst_in = 1'b0;
    cycle(1'b1, 2'b01, 24'h000000, 6'b000000, 12'h000);
    for (int l = 0; l < N; l++) chk("release", l, lane_out(l), 10'b1101010100);
    cycle(1'b1, 2'b01, 24'h000000, 6'b000000, 12'h000);
    chk("release_video", 0, lane_out(0), 10'b0100000000);
    cycle(1'b1, 2'b00, 24'h000000, 6'b000000, 12'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/tmds_encoder_multi.md
# tmds_encoder_multi

Parametrised, pipelined TMDS encoder for NUM_CH parallel HDMI lanes. Each lane independently encodes 8-bit video with DVI transition minimisation and DC balance, 2-bit control codes, TERC4 data-island symbols and video guard bands, selected per cycle by a shared mode input. It sits between the video/packet timing generator and the 10:1 serialisers, and replaces the single-lane encoder. Its behaviour is a two-stage pipeline with a clock enable and per-lane running-disparity state.

## Interface
- NUM_CH, 3, number of TMDS lanes. Lane i uses bits [8i+7:8i], [2i+1:2i], [4i+3:4i] and [10i+9:10i] of the data, control, TERC4 and output buses respectively.
- clk_in  input  1  pixel clock
- rst_in  input  1  reset, asynchronous, active-high
- ce_in  input  1  clock enable; low holds every register
- mode_in  input  2  symbol mode, shared by all lanes: 00 control, 01 video, 10 TERC4, 11 video guard band
- data_in  input  8*NUM_CH  video bytes
- control_in  input  2*NUM_CH  {vs,hs} on lane 0; other lanes use their own bits
- terc4_in  input  4*NUM_CH  TERC4 nibbles
- tmds_out  output  10*NUM_CH  encoded symbols, bit 0 transmitted first

## Operation
- Stage 1, on edge with ce_in=1, registers the following per lane:
  - mode, control, TERC4 nibble;
  - q_m[8:0];
  - N1 = ones(q_m[7:0]) (4-bit) and N0 = 8 − N1.
- q_m rule, with D the video byte:
  - If ones(D)>4, or ones(D)==4 and D[0]==0: q_m[0]=D[0], q_m[i]=~(q_m[i-1]^D[i]), q_m[8]=0.
  - Else: q_m[i]=q_m[i-1]^D[i], q_m[8]=1.
- Stage 2, on edge with ce_in=1, registers tmds_out and updates cnt. cnt is a per-lane signed 5-bit disparity register.
- Video mode, case A: cnt==0 or N1==N0.
  - out = {~q_m8, q_m8, q_m8 ? q_m[7:0] : ~q_m[7:0]}.
  - cnt += q_m8 ? N1−N0 : N0−N1.
- Video mode, case B: (cnt>0 and N1>N0) or (cnt<0 and N0>N1).
  - out = {1, q_m8, ~q_m[7:0]}.
  - cnt += 2·q_m8 + N0 − N1.
- Video mode, case C: otherwise.
  - out = {0, q_m8, q_m[7:0]}.
  - cnt += N1 − N0 − 2·~q_m8.
- Control mode, cnt←0. Control codes: 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011.
- TERC4 mode, cnt←0. Nibble 0..15 maps to:
  - 0..7: 1010011100, 1001100011, 1011100100, 1011100010, 0101110001, 0100011110, 0110001110, 0100111100
  - 8..15: 1011001100, 0100111001, 0110011100, 1011000110, 1010001110, 1001110001, 0101100011, 1011000011
- Guard band mode, cnt←0. Lane with i mod 3 == 1 → 0100110011; all other lanes → 1011001100.
- Disparity arithmetic is signed 5-bit. It stays within −10..+10 by construction; no saturation logic.
- Lanes share no state.

## Timing
- Latency is 2 enabled edges: inputs sampled at enabled edge k appear on tmds_out after enabled edge k+1.
- Throughput is one symbol per lane per enabled cycle.
- ce_in=0: stage 1, stage 2, tmds_out and cnt all hold. The output stream is identical to the unstalled stream with the stalls removed.
- rst_in=1, asserted at any time (including mid-line):
  - immediately forces tmds_out=0 and cnt=0;
  - clears the stage-1 registers to mode=control, control=00, q_m=0, N1=0.
- After rst_in release, the first enabled edge outputs 1101010100 on every lane (the stage-1 reset contents).
- Mode changes take effect per symbol with no bubble. Switching from any non-video mode into video starts with cnt=0.

## Configuration
- TMDS_TERC4_EN defined: TERC4 and guard-band modes are implemented as above.
- TMDS_TERC4_EN undefined: TERC4 table and guard logic are removed, terc4_in is ignored, and modes 10 and 11 encode exactly as control mode (control_in code, cnt←0).

## Test plan
- Reset: drive video data mid-stream, then assert rst_in between edges.
  - tmds_out reads 0 immediately and cnt reads 0.
  - After release with ce_in=1, the first edge gives 1101010100 on all lanes.
- Control: mode 00, lane 0 control_in=01, lane 2 control_in=11 → two edges later 0010101011 on lane 0 and 1010101011 on lane 2.
- Video DC balance: lane 0 data 0x00 for three cycles from cnt=0 → outputs 0100000000, 1111111111, 0100000000; cnt becomes −8, 2, −6.
- Disparity reset: video 0x00, one control cycle, then video 0x00 → second video symbol is again 0100000000 (cnt restarted at 0).
- TERC4/guard (macro on): mode 10 with lane 0 nibble 0xA → 0110011100; mode 11 with NUM_CH=3 → lanes 0/1/2 = 1011001100 / 0100110011 / 1011001100. With the macro off, both cases yield control codes.
- Stall: hold ce_in=0 for 3 cycles inside a random video burst → tmds_out frozen, and the resumed sequence bit-matches a golden model run without stalls.
